// File: rtl/serial_pkg.sv
// Shared definitions for the serial lane scheduler: FSM state encoding,
// requester identifiers and a counter-width helper.
package serial_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  // Width needed to count 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. The grant is combinational. The last-grant
// pointer advances only when the granted word is actually accepted.
module rr_arb2
  import serial_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  input  logic       accept,
  output logic [1:0] gnt,
  output logic       last
);

  // One-hot grant; under contention, the requester not served last wins.
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (last == REQ1) ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  // Pointer starts at REQ1 so requester 0 wins the first contention.
  always_ff @(posedge clk) begin
    if (rst)
      last <= REQ1;
    else if (accept)
      last <= gnt[1];
  end

endmodule

// File: rtl/serial_lane_sched.sv
// Two-requester serial lane scheduler. It arbitrates round-robin between two
// parallel producers, captures the winning word and shifts it out MSB-first
// with frame-valid framing and a fixed inter-frame gap.
module serial_lane_sched
  import serial_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             sout,
  output logic             sout_en,
  output logic             frame_done,
  output logic             grant_id,
  output logic             busy
);

  localparam int CW = cnt_w(WIDTH);
  localparam int GW = cnt_w(GAP + 1);
  localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] BIT_PRE  = CW'(WIDTH - 2);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    bit_cnt;
  logic [GW-1:0]    gap_cnt;
  logic [1:0]       gnt;
  logic             xfer;
  logic             arb_last_unused;
  logic [WIDTH-1:0] win_data;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    ({req1_valid, req0_valid}),
    .en     (state == S_IDLE),
    .accept (xfer),
    .gnt    (gnt),
    .last   (arb_last_unused)
  );

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];
  assign xfer       = |gnt;
  assign win_data   = gnt[1] ? req1_data : req0_data;

  // Next-state logic: IDLE -> SHIFT on handshake, SHIFT -> GAP/IDLE after
  // the last bit, GAP -> IDLE after GAP idle cycles.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (xfer) state_nxt = S_SHIFT;
      S_SHIFT: if (bit_cnt == BIT_LAST) state_nxt = (GAP > 0) ? S_GAP : S_IDLE;
      S_GAP:   if (gap_cnt == GAP_LAST) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  // Shift register, counters and registered outputs. The MSB is presented at
  // the handshake edge so the first bit appears one cycle after the transfer;
  // bit_cnt always holds the index of the bit currently on sout.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg      <= '0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      sout       <= 1'b0;
      sout_en    <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      grant_id   <= REQ0;
    end else begin
      sout       <= 1'b0;
      sout_en    <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (xfer) begin
            shreg    <= {win_data[WIDTH-2:0], 1'b0};
            sout     <= win_data[WIDTH-1];
            sout_en  <= 1'b1;
            busy     <= 1'b1;
            bit_cnt  <= '0;
            grant_id <= gnt[1] ? REQ1 : REQ0;
          end else begin
            busy <= 1'b0;
          end
        end
        S_SHIFT: begin
          if (bit_cnt != BIT_LAST) begin
            sout       <= shreg[WIDTH-1];
            shreg      <= {shreg[WIDTH-2:0], 1'b0};
            sout_en    <= 1'b1;
            bit_cnt    <= bit_cnt + 1'b1;
            frame_done <= (bit_cnt == BIT_PRE);
          end else begin
            gap_cnt <= '0;
            busy    <= (GAP > 0);
          end
        end
        S_GAP: begin
          gap_cnt <= gap_cnt + 1'b1;
          busy    <= (gap_cnt != GAP_LAST);
        end
        default: busy <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_lane_sched.sv
// Bench for serial_lane_sched: one instance with GAP=1 and one with GAP=0,
// a cycle-level timing model of both, and directed scenarios with literal
// expectations.
module tb_serial_lane_sched;

  logic       clk = 1'b0;
  logic       rst [2];
  logic       v0  [2];
  logic       v1  [2];
  logic [3:0] d0  [2];
  logic [3:0] d1  [2];
  logic       rdy0[2];
  logic       rdy1[2];
  logic       sout[2];
  logic       sen [2];
  logic       fd  [2];
  logic       gid [2];
  logic       busy[2];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Model state per instance: last handshake cycle, captured word and winner.
  bit         m_on  [2];
  bit         m_act [2];
  int         m_t0  [2];
  logic [3:0] m_word[2];
  logic       m_gid [2];
  logic       m_last[2];

  serial_lane_sched #(.WIDTH(4), .GAP(1)) u_g1 (
    .clk(clk), .rst(rst[0]),
    .req0_valid(v0[0]), .req0_data(d0[0]), .req0_ready(rdy0[0]),
    .req1_valid(v1[0]), .req1_data(d1[0]), .req1_ready(rdy1[0]),
    .sout(sout[0]), .sout_en(sen[0]), .frame_done(fd[0]),
    .grant_id(gid[0]), .busy(busy[0])
  );

  serial_lane_sched #(.WIDTH(4), .GAP(0)) u_g0 (
    .clk(clk), .rst(rst[1]),
    .req0_valid(v0[1]), .req0_data(d0[1]), .req0_ready(rdy0[1]),
    .req1_valid(v1[1]), .req1_data(d1[1]), .req1_ready(rdy1[1]),
    .sout(sout[1]), .sout_en(sen[1]), .frame_done(fd[1]),
    .grant_id(gid[1]), .busy(busy[1])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every cycle: derive the expected outputs from the timing rules, compare,
  // then advance the model with this cycle's reset or handshake.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int g, k;
      logic [3:0] w;
      logic e_en, e_s, e_fd, e_b, idle, er0, er1;
      g = (i == 0) ? 1 : 0;
      k = cyc - m_t0[i] - 1;
      w = m_word[i];
      e_en = m_act[i] && k >= 0 && k < 4;
      e_s = 1'b0;
      if (e_en) e_s = w[3-k];
      e_fd = e_en && (k == 3);
      e_b  = m_act[i] && k >= 0 && k < 4 + g;
      idle = !m_act[i] || k >= 4 + g;
      er0  = idle && v0[i] && (!v1[i] || m_last[i]);
      er1  = idle && v1[i] && (!v0[i] || !m_last[i]);
      if (m_on[i]) begin
        check($sformatf("u%0d_sout", i), sout[i], e_s);
        check($sformatf("u%0d_sout_en", i), sen[i], e_en);
        check($sformatf("u%0d_frame_done", i), fd[i], e_fd);
        check($sformatf("u%0d_busy", i), busy[i], e_b);
        check($sformatf("u%0d_grant_id", i), gid[i], m_gid[i]);
        if (!rst[i]) begin
          check($sformatf("u%0d_ready0", i), rdy0[i], er0);
          check($sformatf("u%0d_ready1", i), rdy1[i], er1);
        end
      end
      if (rst[i]) begin
        m_on[i]   = 1'b1;
        m_act[i]  = 1'b0;
        m_gid[i]  = 1'b0;
        m_last[i] = 1'b1;
      end else if (m_on[i] && (er0 || er1)) begin
        m_act[i]  = 1'b1;
        m_t0[i]   = cyc;
        m_word[i] = er1 ? d1[i] : d0[i];
        m_gid[i]  = er1;
        m_last[i] = er1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] bits, dn, ws, gs;
    logic [5:0] rp;
    logic [9:0] enp, rdp;
    int n;
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; v0[i] = 1'b0; v1[i] = 1'b0; d0[i] = 4'h0; d1[i] = 4'h0;
    end
    repeat (3) tick();
    rst[0] = 1'b0; rst[1] = 1'b0;
    @(negedge clk);
    check("reset_sout", sout[0], 1'b0);
    check("reset_busy", busy[0], 1'b0);
    check("reset_grant_id", gid[0], 1'b0);
    check("reset_sout_en_g0", sen[1], 1'b0);

    // Single frame 1011 on requester 0, then data capture on a second frame.
    tick();
    v0[0] = 1'b1; d0[0] = 4'b1011;
    @(negedge clk);
    check("t1_ready_at_T", rdy0[0], 1'b1);
    tick();
    v0[0] = 1'b0; d0[0] = 4'b0110;
    bits = '0; dn = '0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bits = {bits[2:0], sout[0]};
      dn   = {dn[2:0], fd[0]};
      tick();
    end
    check("t1_bits", bits, 4'b1011);
    check("t1_frame_done_pos", dn, 4'b0001);
    v0[0] = 1'b1;
    @(negedge clk);
    check("t1_busy_T5", busy[0], 1'b1);
    check("t1_ready_T5", rdy0[0], 1'b0);
    tick();
    @(negedge clk);
    check("t1_ready_T6", rdy0[0], 1'b1);
    tick();
    d0[0] = 4'b1001;
    bits = '0; rp = '0;
    for (int j = 1; j <= 6; j++) begin
      @(negedge clk);
      if (j <= 4) bits = {bits[2:0], sout[0]};
      rp = {rp[4:0], rdy0[0]};
      if (j < 6) tick();
    end
    check("cap_bits", bits, 4'b0110);
    check("cap_ready_pattern", rp, 6'b000001);
    tick();
    v0[0] = 1'b0;
    repeat (8) tick();

    // Fairness after reset: both requesters continuously valid.
    rst[0] = 1'b1;
    tick();
    rst[0] = 1'b0; v0[0] = 1'b1; v1[0] = 1'b1; d0[0] = 4'hA; d1[0] = 4'h5;
    ws = '0; gs = '0;
    for (int f = 0; f < 4; f++) begin
      @(negedge clk);
      n = 0;
      while (!(rdy0[0] || rdy1[0]) && n < 20) begin
        tick();
        @(negedge clk);
        n++;
      end
      check("fair_handshake_timeout", (n < 20), 1'b1);
      ws[f] = rdy1[0];
      tick();
      @(negedge clk);
      gs[f] = gid[0];
    end
    check("fair_winners", ws, 4'b1010);
    check("fair_grant_ids", gs, 4'b1010);
    tick();
    v0[0] = 1'b0; v1[0] = 1'b0;
    repeat (8) tick();

    // Back-to-back on the GAP=0 instance with requester 1 always valid.
    v1[1] = 1'b1; d1[1] = 4'hC;
    @(negedge clk);
    check("b2b_first_ready", rdy1[1], 1'b1);
    enp = '0; rdp = '0;
    for (int j = 1; j <= 10; j++) begin
      tick();
      @(negedge clk);
      enp = {enp[8:0], sen[1]};
      rdp = {rdp[8:0], rdy1[1]};
    end
    check("b2b_sout_en_pattern", enp, 10'b1111011110);
    check("b2b_ready_pattern", rdp, 10'b0000100001);
    tick();
    v1[1] = 1'b0;
    repeat (8) tick();

    // Reset during bit 2 of a frame from requester 0.
    v0[0] = 1'b1; d0[0] = 4'b1111;
    @(negedge clk);
    check("rmid_ready", rdy0[0], 1'b1);
    tick();
    v0[0] = 1'b0;
    tick();
    tick();
    rst[0] = 1'b1;
    @(negedge clk);
    check("rmid_bit2_en", sen[0], 1'b1);
    tick();
    rst[0] = 1'b0; v0[0] = 1'b1; v1[0] = 1'b1;
    @(negedge clk);
    check("rmid_sout", sout[0], 1'b0);
    check("rmid_sout_en", sen[0], 1'b0);
    check("rmid_busy", busy[0], 1'b0);
    check("rmid_no_frame_done", fd[0], 1'b0);
    check("rmid_req0_wins", {rdy1[0], rdy0[0]}, 2'b01);
    tick();
    v0[0] = 1'b0; v1[0] = 1'b0;
    repeat (8) tick();

    // Reset overrides a handshake offered in the same cycle.
    rst[0] = 1'b1; v1[0] = 1'b1; d1[0] = 4'hF;
    tick();
    rst[0] = 1'b0; v1[0] = 1'b0;
    @(negedge clk);
    check("rovr_sout_en", sen[0], 1'b0);
    check("rovr_busy", busy[0], 1'b0);
    check("rovr_grant_id", gid[0], 1'b0);
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/serial_lane_sched.md
# serial_lane_sched

Two-requester scheduler and sequencer for a single serial output lane. It arbitrates between two parallel-word producers with round-robin fairness and captures the winning word. It then drives that word out MSB-first, one bit per clock, with frame-valid framing and a programmable inter-frame gap. It sits between parallel producers and any serial consumer or downstream serial shift-register chain.

## Interface
- WIDTH, 4: frame length in bits; legal range ≥ 2.
- GAP, 1: idle cycles forced between frames; legal range ≥ 0.
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req0_valid  input  1  requester 0 has a word.
- req0_data  input  WIDTH  requester 0 word.
- req0_ready  output  1  requester 0 word accepted this cycle when valid is also high.
- req1_valid  input  1  requester 1 has a word.
- req1_data  input  WIDTH  requester 1 word.
- req1_ready  output  1  requester 1 word accepted this cycle when valid is also high.
- sout  output  1  serial data bit; registered.
- sout_en  output  1  high while sout carries a frame bit; registered.
- frame_done  output  1  one-cycle pulse on the last bit of a frame; registered.
- grant_id  output  1  source of the current or most recent frame; registered.
- busy  output  1  high in SHIFT and GAP states; registered.

## Operation
- FSM states: IDLE, SHIFT, GAP.
- **IDLE**
  - Arbitration is combinational.
  - Exactly one of reqN_ready is high, and only if at least one valid is high.
  - If both valids are high, the requester not granted last wins.
  - If only one valid is high, that requester wins.
  - reqN_ready never asserts outside IDLE.
- **Handshake**
  - A transfer occurs on reqN_valid && reqN_ready.
  - On transfer: load reqN_data into the internal WIDTH-bit shift register, set grant_id=N, update the last-grant pointer to N, clear the bit counter, and go to SHIFT.
  - Data is captured at the handshake; the requester may change it afterwards.
- **SHIFT**
  - Each cycle, sout = shreg[WIDTH-1], then shreg shifts left with 0 fill. sout_en=1.
  - The bit counter counts 0..WIDTH-1.
  - On count WIDTH-1, frame_done=1. Next state is GAP if GAP>0, else IDLE.
- **GAP**
  - sout=0 and sout_en=0 for exactly GAP cycles, then go to IDLE.
- Outside SHIFT: sout=0, sout_en=0, frame_done=0.
- Counter widths are $clog2(WIDTH) and $clog2(GAP+1), with a minimum of 1. No wrap-around occurs within a frame.
- **Reset**
  - state=IDLE, shreg=0, sout=0, sout_en=0, frame_done=0, busy=0, grant_id=0.
  - The last-grant pointer is set to 1, so requester 0 wins the first contention.
  - Reset mid-frame aborts the frame: outputs are 0 on the next cycle, with no frame_done.
  - rst overrides any handshake in the same cycle. No transfer occurs and ready has no effect.

## Timing
- Handshake in cycle T:
  - Bit k (k=0..WIDTH-1, MSB first) appears on sout with sout_en=1 in cycle T+1+k.
  - frame_done=1 in cycle T+WIDTH.
  - busy=1 from cycle T+1 to T+WIDTH+GAP.
  - The next handshake is possible no earlier than cycle T+WIDTH+GAP+1.
- Minimum frame period is WIDTH+GAP+1 cycles. Throughput with GAP=0 is WIDTH/(WIDTH+1).
- Latency from handshake to first bit is 1 cycle.
- Simultaneous valid on both requesters in IDLE: one grant only; the loser keeps waiting with ready=0.
- A valid dropped before its handshake is not recorded and does not affect the pointer.

## Structure
- Shared package serial_pkg holds:
  - state encodings IDLE=2'd0, SHIFT=2'd1, GAP=2'd2;
  - grant id constants REQ0=1'b0, REQ1=1'b1.
- Sub-module rr_arb2 is a two-way round-robin arbiter.
  - Inputs: clk, rst, req[1:0], en, accept.
  - Outputs: gnt[1:0] (one-hot or zero), and a last pointer that updates on accept.
- The shift register, counters and FSM are implemented inline in serial_lane_sched.

## Test plan
- **Single frame:** WIDTH=4, GAP=1; req0 sends 4'b1011 at T.
  - sout=1,0,1,1 at T+1..T+4 with sout_en=1; frame_done only at T+4.
  - busy through T+5; req0_ready can be high again at T+6.
- **Fairness:** both valid continuously with req0=4'hA and req1=4'h5.
  - Frames alternate A,5,A,5 with grant_id 0,1,0,1.
  - The first grant goes to requester 0 after reset.
- **Back-to-back, GAP=0:** req1 is continuously valid.
  - Handshakes occur every 5 cycles; sout_en drops for exactly 1 cycle between frames.
- **Reset mid-frame:** assert rst at bit 2 of a frame.
  - Next cycle: sout=0, sout_en=0, busy=0, and no frame_done.
  - The following contention is won by req0.
- **Data capture:** change req0_data the cycle after the handshake.
  - The serialized bits match the value captured at the handshake.
  - ready stays 0 during SHIFT and GAP regardless of valid.
